shift_reg_ctl: RTL

- Parametrised successor to the team's single-bit D flip-flop. It is a WIDTH-bit register with sync reset and sync set, complementary outputs q/qbar, and a per-cycle mode (hold/load/shift/rotate).
- Adds an auto-shift sequencer: one start command shifts the register amt times, then pulses done.
- Used as the general storage/serialiser primitive in datapaths and serial links.

---
 rtl/shift_reg_pkg.sv | 65 ++++++
 rtl/shift_reg_seq.sv | 96 +++++++++
 rtl/shift_reg_ctl.sv | 98 +++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_reg_pkg: mode/state encodings and the shared shift operator   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package shift_reg_pkg;

  // Widest register shift_op can serve; callers zero-extend into this.
  localparam int c_MAXW = 64;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROTL = 3'd4,
    MODE_ROTR = 3'd5,
    MODE_ASR  = 3'd6,
    MODE_RSVD = 3'd7
  } mode_e;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_e;

  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ASR);
  endfunction

  // Returns {out_bit, next_q}; only the low w bits of next_q are meaningful
  // and the bits above them come back zero.
  function automatic logic [c_MAXW:0] shift_op(
    input logic [c_MAXW-1:0] q,
    input logic [2:0]        mode,
    input logic              sin,
    input int unsigned       w
  );
    logic [c_MAXW-1:0] one;
    logic [c_MAXW-1:0] topbit;
    logic [c_MAXW-1:0] mask;
    logic [c_MAXW-1:0] nq;
    logic              msb;
    logic              lsb;
    logic              ob;
    one    = {{(c_MAXW-1){1'b0}}, 1'b1};
    topbit = one << (w - 1);
    mask   = {c_MAXW{1'b1}} >> (c_MAXW - w);
    msb    = |(q & topbit);
    lsb    = q[0];
    nq     = q;
    ob     = 1'b0;
    case (mode)
      MODE_SHL:  begin nq = (q << 1) | (sin ? one    : '0); ob = msb; end
      MODE_SHR:  begin nq = (q >> 1) | (sin ? topbit : '0); ob = lsb; end
      MODE_ROTL: begin nq = (q << 1) | (msb ? one    : '0); ob = msb; end
      MODE_ROTR: begin nq = (q >> 1) | (lsb ? topbit : '0); ob = lsb; end
      MODE_ASR:  begin nq = (q >> 1) | (msb ? topbit : '0); ob = lsb; end
      default:   begin nq = q; ob = 1'b0; end
    endcase
    return {ob, nq & mask};
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_reg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_reg_seq: auto-shift sequencer (FSM, shift counter, done)      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module shift_reg_seq
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set,
  input  logic            start,
  input  logic [2:0]      mode,
  input  logic [CNTW-1:0] amt,
  output logic            step_en,
  output logic [2:0]      lat_mode,
  output logic            idle,
  output logic            busy,
  output logic            done
);

  localparam logic [CNTW-1:0] c_AMT_MAX = CNTW'(WIDTH);
  localparam logic [CNTW-1:0] c_CNT_ONE = CNTW'(1);

  state_e          r_state;
  state_e          w_state_nx;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cnt_nx;
  logic [CNTW-1:0] w_amt_sat;
  logic [2:0]      r_mode;
  logic [2:0]      w_mode_nx;
  logic            r_done;
  logic            w_done_nx;

  assign w_amt_sat = (amt > c_AMT_MAX) ? c_AMT_MAX : amt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= MODE_HOLD;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_mode  <= w_mode_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_mode_nx  = r_mode;
    w_done_nx  = 1'b0;
    step_en    = 1'b0;
    if (set) begin
      // Abort: drop any run in progress without reporting completion.
      w_state_nx = IDLE;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if ((w_amt_sat != '0) && is_shift_mode(mode)) begin
              w_mode_nx  = mode;
              w_cnt_nx   = w_amt_sat;
              w_state_nx = SHIFTING;
            end else begin
              w_done_nx = 1'b1;
            end
          end
        end
        SHIFTING: begin
          step_en  = 1'b1;
          w_cnt_nx = r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  assign idle     = (r_state == IDLE);
  assign busy     = (r_state == SHIFTING);
  assign lat_mode = r_mode;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/shift_reg_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | shift_reg_ctl: WIDTH-bit register, manual modes plus auto-shift     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module shift_reg_ctl
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}},
  parameter int               CNTW      = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNTW-1:0]  amt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0]  r_q;
  logic              r_sout;
  logic              w_step_en;
  logic [2:0]        w_lat_mode;
  logic              w_idle;
  logic              w_manual;
  logic [2:0]        w_op_mode;
  logic [c_MAXW-1:0] w_q_ext;
  logic [c_MAXW:0]   w_op;
  logic [WIDTH-1:0]  w_shift_q;
  logic              w_shift_out;

  shift_reg_seq #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .set      (set),
    .start    (start),
    .mode     (mode),
    .amt      (amt),
    .step_en  (w_step_en),
    .lat_mode (w_lat_mode),
    .idle     (w_idle),
    .busy     (busy),
    .done     (done)
  );

  // A start request owns the IDLE cycle it arrives in, so no manual op then.
  assign w_manual    = w_idle & ~start & en;
  assign w_op_mode   = w_step_en ? w_lat_mode : mode;
  assign w_q_ext     = c_MAXW'(r_q);
  assign w_op        = shift_op(w_q_ext, w_op_mode, sin, unsigned'(WIDTH));
  assign w_shift_q   = w_op[WIDTH-1:0];
  assign w_shift_out = w_op[c_MAXW];

  generate
    if (WIDTH < c_MAXW) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^w_op[c_MAXW-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
    end else if (set) begin
      r_q <= SET_VAL;
    end else if (w_step_en) begin
      r_q    <= w_shift_q;
      r_sout <= w_shift_out;
    end else if (w_manual) begin
      if (is_shift_mode(mode)) begin
        r_q    <= w_shift_q;
        r_sout <= w_shift_out;
      end else if (mode == MODE_LOAD) begin
        r_q <= d;
      end
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;
  assign sout = r_sout;

endmodule
`default_nettype wire
